// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC source encoding, fetch-unit defaults and small helpers.
package cpu_pkg;

    typedef enum logic [2:0] {SEQ, JMP, BR, JR, ERET, EXC} pc_src_t;

    localparam int          PC_IMM_W     = 26;
    localparam int          PC_OFF_W     = 16;
    localparam logic [31:0] PC_RESET_VEC = 32'h0000_3000;
    localparam logic [31:0] PC_EXC_VEC   = 32'h0000_4180;

    function automatic logic word_misaligned(input logic [1:0] lsbs);
        return lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_unit_if.sv
// Fetch-stage control/status bundle between the pipeline (master) and pc_next_unit (slave).
interface pc_next_unit_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int IMM_W  = PC_IMM_W,
    parameter int OFF_W  = PC_OFF_W
);
    logic              stall;
    logic              jmp_valid;
    logic              jmp_link;
    logic [IMM_W-1:0]  jmp_imm;
    logic              br_taken;
    logic [OFF_W-1:0]  br_off;
    logic              jr_valid;
    logic              jr_is_ret;
    logic [ADDR_W-1:0] jr_addr;
    logic              exc_req;
    logic              eret;
    logic [ADDR_W-1:0] epc_in;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              redirect;
    logic              misalign_err;
    logic              ras_mispredict;
    logic              ras_empty;

    modport master (
        output stall, jmp_valid, jmp_link, jmp_imm, br_taken, br_off,
               jr_valid, jr_is_ret, jr_addr, exc_req, eret, epc_in,
        input  pc, pc_plus4, redirect, misalign_err, ras_mispredict, ras_empty
    );

    modport slave (
        input  stall, jmp_valid, jmp_link, jmp_imm, br_taken, br_off,
               jr_valid, jr_is_ret, jr_addr, exc_req, eret, epc_in,
        output pc, pc_plus4, redirect, misalign_err, ras_mispredict, ras_empty
    );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_empty;
    logic [PTR_W-1:0]  w_top_idx;
    logic [CNT_W-1:0]  w_count_next;

    // r_ptr is the next write slot, so the top lives one below it (wrapping).
    assign w_top_idx = r_ptr - 1'b1;
    assign top       = r_mem[w_top_idx];
    assign empty     = r_empty;

    always_comb begin
        w_count_next = r_count;
        if (push) begin
            if (r_count != CNT_W'(RAS_DEPTH))
                w_count_next = r_count + 1'b1;
        end else if (pop && r_count != '0) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
        end else begin
            if (push)
                r_ptr <= r_ptr + 1'b1;
            else if (pop && r_count != '0)
                r_ptr <= w_top_idx;
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            r_mem[r_ptr] <= push_data;
    end

endmodule

// File: rtl/pc_next_unit.sv
// Next-PC generator: priority source mux, jump/branch target arithmetic,
// registered PC with stall, and one-cycle status pulses.
module pc_next_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                IMM_W     = PC_IMM_W,
    parameter int                OFF_W     = PC_OFF_W,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_RESET_VEC),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(PC_EXC_VEC),
    parameter int                RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_next_unit_if.slave bus
);
    logic [ADDR_W-1:0] r_pc;
    logic              r_redirect;
    logic              r_misalign;
    logic              r_mispredict;

    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_jmp_target;
    logic [ADDR_W-1:0] w_br_target;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_ras_top;
    pc_src_t           w_src;
    logic              w_hold;
    logic              w_misalign;
    logic              w_push;
    logic              w_pop;
    logic              w_mispredict;
    logic              w_ras_empty;

    assign w_pc_plus4 = r_pc + ADDR_W'(4);

    generate
        if (ADDR_W > IMM_W + 2) begin : g_jmp_region
            assign w_jmp_target = {w_pc_plus4[ADDR_W-1:IMM_W+2], bus.jmp_imm, 2'b00};
        end else begin : g_jmp_full
            assign w_jmp_target = {bus.jmp_imm, 2'b00};
        end
    endgenerate

    // Word offset, sign-extended and scaled to bytes; the add wraps modulo 2^ADDR_W.
    assign w_br_target = w_pc_plus4 +
        {{(ADDR_W-OFF_W-2){bus.br_off[OFF_W-1]}}, bus.br_off, 2'b00};

    always_comb begin
        w_src = SEQ;
        if (bus.exc_req)       w_src = EXC;
        else if (bus.eret)     w_src = ERET;
        else if (bus.jr_valid) w_src = JR;
        else if (bus.br_taken) w_src = BR;
        else if (bus.jmp_valid) w_src = JMP;

        w_hold     = bus.stall && !bus.exc_req && !bus.eret;
        w_misalign = 1'b0;
        w_pc_next  = w_pc_plus4;
        case (w_src)
            EXC:  w_pc_next = EXC_VEC;
            ERET: begin
                w_misalign = word_misaligned(bus.epc_in[1:0]);
                w_pc_next  = w_misalign ? EXC_VEC : bus.epc_in;
            end
            JR: begin
                w_misalign = word_misaligned(bus.jr_addr[1:0]);
                w_pc_next  = w_misalign ? EXC_VEC : bus.jr_addr;
            end
            BR:      w_pc_next = w_br_target;
            JMP:     w_pc_next = w_jmp_target;
            default: w_pc_next = w_pc_plus4;
        endcase

        w_push       = !w_hold && (w_src == JMP) && bus.jmp_link;
        w_pop        = !w_hold && (w_src == JR) && bus.jr_is_ret;
        w_mispredict = w_pop && (w_ras_empty || (w_ras_top != bus.jr_addr));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_VEC;
            r_redirect   <= 1'b0;
            r_misalign   <= 1'b0;
            r_mispredict <= 1'b0;
        end else if (w_hold) begin
            r_redirect   <= 1'b0;
            r_misalign   <= 1'b0;
            r_mispredict <= 1'b0;
        end else begin
            r_pc         <= w_pc_next;
            r_redirect   <= (w_src != SEQ);
            r_misalign   <= w_misalign;
            r_mispredict <= w_mispredict;
        end
    end

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_plus4),
        .top       (w_ras_top),
        .empty     (w_ras_empty)
    );

    assign bus.pc             = r_pc;
    assign bus.pc_plus4       = w_pc_plus4;
    assign bus.redirect       = r_redirect;
    assign bus.misalign_err   = r_misalign;
    assign bus.ras_mispredict = r_mispredict;
    assign bus.ras_empty      = w_ras_empty;

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: a behavioural model predicts each cycle's outputs.
module tb_pc_next_unit;
    import cpu_pkg::*;

    localparam int          ADDR_W    = 32;
    localparam int          IMM_W     = 26;
    localparam int          OFF_W     = 16;
    localparam int          RAS_DEPTH = 4;
    localparam logic [31:0] RST_V     = 32'h0000_3000;
    localparam logic [31:0] EXC_V     = 32'h0000_4180;

    typedef struct packed {
        logic [31:0] pc;
        logic        redirect;
        logic        misalign;
        logic        mispredict;
        logic        empty;
    } exp_t;

    typedef struct packed {
        logic        stall, jmp, link;
        logic [25:0] imm;
        logic        br;
        logic [15:0] off;
        logic        jr, ret;
        logic [31:0] jaddr;
        logic        exc, eret;
        logic [31:0] epc;
    } op_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pc_next_unit_if #(.ADDR_W(ADDR_W), .IMM_W(IMM_W), .OFF_W(OFF_W)) bus ();

    pc_next_unit #(
        .ADDR_W(ADDR_W), .IMM_W(IMM_W), .OFF_W(OFF_W),
        .RESET_VEC(RST_V), .EXC_VEC(EXC_V), .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic exp_t observe();
        return {bus.pc, bus.redirect, bus.misalign_err, bus.ras_mispredict, bus.ras_empty};
    endfunction

    function automatic string fmt(input exp_t x);
        return $sformatf("pc=%h rd=%0b ma=%0b mp=%0b em=%0b",
                         x.pc, x.redirect, x.misalign, x.mispredict, x.empty);
    endfunction

    function automatic op_t op_seq();
        return '0;
    endfunction
    function automatic op_t op_jal(input logic [25:0] imm, input logic link);
        op_t o = '0; o.jmp = 1'b1; o.link = link; o.imm = imm; return o;
    endfunction
    function automatic op_t op_br(input logic [15:0] off);
        op_t o = '0; o.br = 1'b1; o.off = off; return o;
    endfunction
    function automatic op_t op_jr(input logic [31:0] addr, input logic ret);
        op_t o = '0; o.jr = 1'b1; o.ret = ret; o.jaddr = addr; return o;
    endfunction

    task automatic model_reset();
        m_pc = RST_V;
        m_ras.delete();
        sb.delete();
    endtask

    task automatic clear_inputs();
        bus.stall = 0; bus.jmp_valid = 0; bus.jmp_link = 0; bus.jmp_imm = '0;
        bus.br_taken = 0; bus.br_off = '0; bus.jr_valid = 0; bus.jr_is_ret = 0;
        bus.jr_addr = '0; bus.exc_req = 0; bus.eret = 0; bus.epc_in = '0;
    endtask

    // Apply one cycle of stimulus, predict its outcome, then step past the edge.
    task automatic drive(input op_t o);
        exp_t        e;
        logic [31:0] pc4;
        logic [31:0] top;
        int          soff;
        bus.stall = o.stall; bus.jmp_valid = o.jmp; bus.jmp_link = o.link; bus.jmp_imm = o.imm;
        bus.br_taken = o.br; bus.br_off = o.off; bus.jr_valid = o.jr; bus.jr_is_ret = o.ret;
        bus.jr_addr = o.jaddr; bus.exc_req = o.exc; bus.eret = o.eret; bus.epc_in = o.epc;
        pc4 = m_pc + 32'd4;
        e = '0;
        e.pc = m_pc;
        if (!(o.stall && !o.exc && !o.eret)) begin
            e.redirect = 1'b1;
            if (o.exc) begin
                e.pc = EXC_V;
            end else if (o.eret) begin
                e.misalign = (o.epc[1:0] != 2'b00);
                e.pc = e.misalign ? EXC_V : o.epc;
            end else if (o.jr) begin
                e.misalign = (o.jaddr[1:0] != 2'b00);
                e.pc = e.misalign ? EXC_V : o.jaddr;
                if (o.ret) begin
                    if (m_ras.size() == 0) begin
                        e.mispredict = 1'b1;
                    end else begin
                        top = m_ras.pop_back();
                        e.mispredict = (top != o.jaddr);
                    end
                end
            end else if (o.br) begin
                soff = $signed(o.off);
                e.pc = pc4 + 32'(soff * 4);
            end else if (o.jmp) begin
                e.pc = {pc4[31:28], o.imm, 2'b00};
                if (o.link) begin
                    if (m_ras.size() == RAS_DEPTH) m_ras.delete(0);
                    m_ras.push_back(pc4);
                end
            end else begin
                e.pc = pc4;
                e.redirect = 1'b0;
            end
        end
        e.empty = (m_ras.size() == 0);
        m_pc = e.pc;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e, got;
        logic [31:0] want[2];
        want[0] = 32'h3004; want[1] = 32'h3008;
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        got = observe(); e = {RST_V, 4'b0001}; n_vec++;
        if (got !== e) begin n_err++; $display("FAIL reset_state: got %s, required %s", fmt(got), fmt(e)); end
        else $display("ok   reset_state: %s", fmt(got));
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(op_seq());
            e = sb.pop_front(); got = observe(); n_vec++;
            if (got !== e || got.pc !== want[i] || bus.pc_plus4 !== want[i] + 32'd4) begin
                n_err++;
                $display("FAIL reset_seq%0d: got %s pc4=%h, required %s pc=%h", i, fmt(got), bus.pc_plus4, fmt(e), want[i]);
            end else $display("ok   reset_seq%0d: %s", i, fmt(got));
        end
    endtask

    task automatic test_jump_branch_ret();
        exp_t e, got;
        op_t ops[3];
        logic [31:0] want[3];
        ops[0] = op_jal(26'h0000C40, 1'b1); want[0] = 32'h0000_3100;
        ops[1] = op_br(16'hFFFE);           want[1] = 32'h0000_30FC;
        ops[2] = op_jr(32'h0000_300C, 1'b1); want[2] = 32'h0000_300C;
        for (int i = 0; i < 3; i++) begin
            drive(ops[i]);
            e = sb.pop_front(); got = observe(); n_vec++;
            if (got !== e || got.pc !== want[i] || got.redirect !== 1'b1) begin
                n_err++;
                $display("FAIL jbr_step%0d: got %s, required %s pc=%h", i, fmt(got), fmt(e), want[i]);
            end else $display("ok   jbr_step%0d: %s", i, fmt(got));
        end
        n_vec++;
        if (got.mispredict !== 1'b0 || got.empty !== 1'b1) begin
            n_err++;
            $display("FAIL jbr_ret_flags: got mp=%b em=%b, required mp=0 em=1", got.mispredict, got.empty);
        end else $display("ok   jbr_ret_flags: mp=0 em=1");
    endtask

    task automatic test_misalign();
        exp_t e, got;
        for (int i = 0; i < 2; i++) begin
            drive(i == 0 ? op_jr(32'h0000_3002, 1'b0) : op_seq());
            e = sb.pop_front(); got = observe(); n_vec++;
            if (got !== e || got.misalign !== (i == 0) || got.pc !== (i == 0 ? EXC_V : EXC_V + 32'd4)) begin
                n_err++;
                $display("FAIL misalign_step%0d: got %s, required %s", i, fmt(got), fmt(e));
            end else $display("ok   misalign_step%0d: %s", i, fmt(got));
        end
    endtask

    task automatic test_stall();
        exp_t e, got;
        op_t ops[6];
        logic [31:0] want[6];
        ops[0] = op_br(16'h0004);
        ops[1] = op_seq();
        ops[2] = op_jal(26'h0001000, 1'b1);
        ops[3] = op_jr(32'h0000_3002, 1'b0);
        ops[4] = op_seq(); ops[4].exc = 1'b1;
        ops[5] = op_seq(); ops[5].eret = 1'b1; ops[5].epc = 32'h0000_3000;
        want = '{32'h4184, 32'h4184, 32'h4184, 32'h4184, 32'h4180, 32'h3000};
        for (int i = 0; i < 6; i++) begin
            ops[i].stall = 1'b1;
            drive(ops[i]);
            e = sb.pop_front(); got = observe(); n_vec++;
            if (got !== e || got.pc !== want[i] || got.redirect !== (i >= 4) || got.misalign !== 1'b0) begin
                n_err++;
                $display("FAIL stall_step%0d: got %s, required %s pc=%h", i, fmt(got), fmt(e), want[i]);
            end else $display("ok   stall_step%0d: %s", i, fmt(got));
        end
    endtask

    task automatic test_priority();
        exp_t e, got;
        op_t ops[5];
        logic [31:0] want[5];
        ops[0] = op_jal(26'h0001000, 1'b1);
        ops[0].br = 1; ops[0].off = 16'h0004; ops[0].jr = 1; ops[0].ret = 1;
        ops[0].jaddr = 32'h5000; ops[0].eret = 1; ops[0].epc = 32'h3000; ops[0].exc = 1;
        ops[1] = ops[0]; ops[1].exc = 0; ops[1].epc = 32'h0000_5000;
        ops[2] = ops[1]; ops[2].eret = 0; ops[2].ret = 0; ops[2].jaddr = 32'h0000_6000;
        ops[3] = ops[2]; ops[3].jr = 0; ops[3].off = 16'h0008;
        ops[4] = op_seq(); ops[4].eret = 1; ops[4].epc = 32'h0000_5001;
        want = '{32'h4180, 32'h5000, 32'h6000, 32'h6024, 32'h4180};
        for (int i = 0; i < 5; i++) begin
            drive(ops[i]);
            e = sb.pop_front(); got = observe(); n_vec++;
            if (got !== e || got.pc !== want[i] || got.empty !== 1'b1) begin
                n_err++;
                $display("FAIL prio_step%0d: got %s, required %s pc=%h", i, fmt(got), fmt(e), want[i]);
            end else $display("ok   prio_step%0d: %s", i, fmt(got));
        end
    endtask

    task automatic test_ras_overflow();
        exp_t e, got;
        logic [31:0] rets[5];
        for (int i = 0; i < 5; i++) begin
            rets[i] = m_pc + 32'd4;
            drive(op_jal(26'h0002000 + 26'(i * 'h40), 1'b1));
            e = sb.pop_front(); got = observe(); n_vec++;
            if (got !== e || got.empty !== 1'b0) begin
                n_err++; $display("FAIL ras_push%0d: got %s, required %s", i, fmt(got), fmt(e));
            end else $display("ok   ras_push%0d: %s", i, fmt(got));
        end
        for (int k = 0; k < 5; k++) begin
            drive(op_jr(rets[4-k], 1'b1));
            e = sb.pop_front(); got = observe(); n_vec++;
            if (got !== e || got.mispredict !== (k == 4) || got.empty !== (k >= 3)) begin
                n_err++; $display("FAIL ras_pop%0d: got %s, required %s", k, fmt(got), fmt(e));
            end else $display("ok   ras_pop%0d: %s", k, fmt(got));
        end
        drive(op_jal(26'h0002400, 1'b1));
        e = sb.pop_front(); got = observe(); n_vec++;
        if (got !== e || got.pc !== 32'h0000_9000) begin
            n_err++; $display("FAIL ras_push_last: got %s, required %s", fmt(got), fmt(e));
        end else $display("ok   ras_push_last: %s", fmt(got));
        drive(op_jr(32'h0000_7000, 1'b1));
        e = sb.pop_front(); got = observe(); n_vec++;
        if (got !== e || got.mispredict !== 1'b1 || got.empty !== 1'b1) begin
            n_err++; $display("FAIL ras_wrong_addr: got %s, required %s", fmt(got), fmt(e));
        end else $display("ok   ras_wrong_addr: %s", fmt(got));
    endtask

    task automatic test_back_to_back();
        exp_t e, got;
        op_t ops[6];
        logic [31:0] want[6];
        ops[0] = op_jr(32'h0000_1000, 1'b0);
        ops[1] = op_br(16'h8000);
        ops[2] = op_jal(26'h0000400, 1'b0);
        ops[3] = op_br(16'h0001);
        ops[4] = op_jr(32'h0000_3000, 1'b0);
        ops[5] = op_seq();
        want = '{32'h0000_1000, 32'hFFFE_1004, 32'hF000_1000, 32'hF000_1008, 32'h0000_3000, 32'h0000_3004};
        for (int i = 0; i < 6; i++) begin
            drive(ops[i]);
            e = sb.pop_front(); got = observe(); n_vec++;
            if (got !== e || got.pc !== want[i] || got.redirect !== (i < 5)) begin
                n_err++;
                $display("FAIL b2b_step%0d: got %s, required %s pc=%h", i, fmt(got), fmt(e), want[i]);
            end else $display("ok   b2b_step%0d: %s", i, fmt(got));
        end
    endtask

    task automatic test_reset_mid();
        exp_t e, got;
        drive(op_jal(26'h0000C40, 1'b1));
        e = sb.pop_front(); got = observe(); n_vec++;
        if (got !== e || got.redirect !== 1'b1) begin
            n_err++; $display("FAIL midrst_jal: got %s, required %s", fmt(got), fmt(e));
        end else $display("ok   midrst_jal: %s", fmt(got));
        bus.stall = 1'b1;
        rst_n = 1'b0;
        #1;
        got = observe(); e = {RST_V, 4'b0001}; n_vec++;
        if (got !== e) begin
            n_err++; $display("FAIL midrst_async: got %s, required %s", fmt(got), fmt(e));
        end else $display("ok   midrst_async: %s", fmt(got));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(op_seq());
        e = sb.pop_front(); got = observe(); n_vec++;
        if (got !== e || got.pc !== 32'h0000_3004) begin
            n_err++; $display("FAIL midrst_release: got %s, required %s", fmt(got), fmt(e));
        end else $display("ok   midrst_release: %s", fmt(got));
    endtask

    initial begin
        test_reset();
        test_jump_branch_ret();
        test_misalign();
        test_stall();
        test_priority();
        test_ras_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
